// File: rtl/cmd_dma_engine.sv
// Multi-channel command engine: per-channel command queues, round-robin
// arbitration and a single-port word-transfer engine for COPY/FILL.
//
// state   | meaning
// IDLE    | waiting for a non-empty queue; pops the selected command
// LOAD    | command registered; decode opcode and length
// RD_REQ  | COPY: read request to src+idx, held until granted
// RD_WAIT | COPY: waiting for read data of the single outstanding read
// WR_REQ  | write request to dst+idx, held until granted
// DONE    | one-cycle completion pulse for the current command
module cmd_dma_engine #(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int LEN_W      = 8
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NUM_CH-1:0]                           cmd_valid,
   output logic [NUM_CH-1:0]                           cmd_ready,
   input  logic [2*NUM_CH-1:0]                         cmd_op,
   input  logic [NUM_CH*ADDR_W-1:0]                    cmd_src,
   input  logic [NUM_CH*ADDR_W-1:0]                    cmd_dst,
   input  logic [NUM_CH*LEN_W-1:0]                     cmd_len,
   output logic                                        mem_req,
   output logic                                        mem_we,
   output logic [ADDR_W-1:0]                           mem_addr,
   output logic [DATA_W-1:0]                           mem_wdata,
   input  logic                                        mem_gnt,
   input  logic                                        mem_rvalid,
   input  logic [DATA_W-1:0]                           mem_rdata,
   output logic                                        done_valid,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] done_ch,
   output logic                                        done_err,
   output logic                                        busy
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 2 + 2*ADDR_W + LEN_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      WR_REQ  = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic [ENT_W-1:0]  q_mem    [NUM_CH][FIFO_DEPTH];
   logic [PTR_W-1:0]  q_wr_ptr [NUM_CH];
   logic [PTR_W-1:0]  q_rd_ptr [NUM_CH];
   logic [PTR_W:0]    q_count  [NUM_CH];
   logic [NUM_CH-1:0] q_full;
   logic [NUM_CH-1:0] q_empty;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;

   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   sel;
   logic [CH_W-1:0]   rr_nxt;
   logic              found;
   logic [CH_W:0]     cand;
   logic [ENT_W-1:0]  head;

   logic [1:0]        cur_op;
   logic [ADDR_W-1:0] cur_src;
   logic [ADDR_W-1:0] cur_dst;
   logic [LEN_W-1:0]  cur_len;
   logic [CH_W-1:0]   cur_ch;
   logic [LEN_W-1:0]  idx;
   logic [DATA_W-1:0] rdata_q;
   logic              last_word;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         q_full[c]  = (q_count[c] == (PTR_W+1)'(FIFO_DEPTH));
         q_empty[c] = (q_count[c] == '0);
      end
   end

   // ready comes from registered occupancy only, so a full queue never
   // accepts a push even in the cycle it is popped
   assign cmd_ready = ~q_full;
   assign push      = cmd_valid & ~q_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            q_wr_ptr[c] <= '0;
            q_rd_ptr[c] <= '0;
            q_count[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) q_wr_ptr[c] <= q_wr_ptr[c] + PTR_W'(1);
            if (pop[c])  q_rd_ptr[c] <= q_rd_ptr[c] + PTR_W'(1);
            case ({push[c], pop[c]})
               2'b10:   q_count[c] <= q_count[c] + (PTR_W+1)'(1);
               2'b01:   q_count[c] <= q_count[c] - (PTR_W+1)'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (push[c]) begin
            q_mem[c][q_wr_ptr[c]] <= {cmd_op[2*c +: 2],
                                      cmd_src[c*ADDR_W +: ADDR_W],
                                      cmd_dst[c*ADDR_W +: ADDR_W],
                                      cmd_len[c*LEN_W +: LEN_W]};
         end
      end
   end

   // round-robin search starting at rr_ptr, wrapping at NUM_CH
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, rr_ptr} + (CH_W+1)'(i);
         if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
         if (!found && !q_empty[cand[CH_W-1:0]]) begin
            found = 1'b1;
            sel   = cand[CH_W-1:0];
         end
      end
   end

   assign rr_nxt = (sel == CH_W'(NUM_CH-1)) ? '0 : sel + CH_W'(1);
   assign head   = q_mem[sel][q_rd_ptr[sel]];

   always_comb begin
      pop = '0;
      if (state == IDLE && found) pop[sel] = 1'b1;
   end

   assign last_word = (idx == cur_len - LEN_W'(1));
   assign busy      = (state != IDLE) || !(&q_empty);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      done_valid = 1'b0;
      done_ch    = '0;
      done_err   = 1'b0;
      case (state)
         IDLE: begin
            if (found) state_nxt = LOAD;
         end
         LOAD: begin
            if (cur_op[1] || cur_len == '0) state_nxt = DONE;
            else if (cur_op[0])             state_nxt = WR_REQ;
            else                            state_nxt = RD_REQ;
         end
         RD_REQ: begin
            mem_req  = 1'b1;
            mem_addr = cur_src + ADDR_W'(idx);
            if (mem_gnt) state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid) state_nxt = WR_REQ;
         end
         WR_REQ: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cur_dst + ADDR_W'(idx);
            mem_wdata = cur_op[0] ? DATA_W'(cur_src) : rdata_q;
            if (mem_gnt) begin
               if (last_word)      state_nxt = DONE;
               else if (cur_op[0]) state_nxt = WR_REQ;
               else                state_nxt = RD_REQ;
            end
         end
         DONE: begin
            done_valid = 1'b1;
            done_ch    = cur_ch;
            done_err   = cur_op[1];
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         cur_op  <= '0;
         cur_src <= '0;
         cur_dst <= '0;
         cur_len <= '0;
         cur_ch  <= '0;
         idx     <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  cur_op  <= head[ENT_W-1 -: 2];
                  cur_src <= head[2*ADDR_W+LEN_W-1 -: ADDR_W];
                  cur_dst <= head[ADDR_W+LEN_W-1 -: ADDR_W];
                  cur_len <= head[LEN_W-1:0];
                  cur_ch  <= sel;
                  rr_ptr  <= rr_nxt;
               end
            end
            LOAD:    idx <= '0;
            RD_WAIT: if (mem_rvalid) rdata_q <= mem_rdata;
            WR_REQ:  if (mem_gnt) idx <= idx + LEN_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_dma_engine.sv
// Scoreboard bench for cmd_dma_engine: a memory model grants and answers
// requests while expected reads, writes and completions are popped in order.
module tb_cmd_dma_engine;
   localparam int NUM_CH     = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 32;
   localparam int LEN_W      = 8;
   localparam int CH_W       = 2;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [NUM_CH-1:0]        cmd_valid = '0;
   logic [NUM_CH-1:0]        cmd_ready;
   logic [2*NUM_CH-1:0]      cmd_op = '0;
   logic [NUM_CH*ADDR_W-1:0] cmd_src = '0;
   logic [NUM_CH*ADDR_W-1:0] cmd_dst = '0;
   logic [NUM_CH*LEN_W-1:0]  cmd_len = '0;
   logic                     mem_req, mem_we;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wdata;
   logic                     mem_gnt = 1'b0;
   logic                     mem_rvalid = 1'b0;
   logic [DATA_W-1:0]        mem_rdata = '0;
   logic                     done_valid;
   logic [CH_W-1:0]          done_ch;
   logic                     done_err;
   logic                     busy;

   cmd_dma_engine #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W),
                    .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .done_valid(done_valid), .done_ch(done_ch), .done_err(done_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
   logic [ADDR_W-1:0]        exp_rd_q[$];
   logic [CH_W:0]            exp_done_q[$];
   int                       wr_cyc_q[$];
   int                       done_cyc_q[$];
   int                       done_seen = 0;
   int                       req_cycles = 0;
   int                       wr_granted = 0;
   int                       gnt_mode = 0;   // 0 always, 1 random, 2 never, 3 reads + first 2 writes
   bit                       spurious = 0;
   bit                       rd_pending = 0;
   int                       rd_cnt = 0;
   logic [DATA_W-1:0]        rd_data = '0;
   logic                     prev_req = 0, prev_gnt = 0, prev_we = 0;
   logic [ADDR_W-1:0]        prev_addr = '0;
   logic [DATA_W-1:0]        prev_wdata = '0;

   // memory target model and output monitor, evaluated on the falling edge
   initial begin
      logic [ADDR_W+DATA_W-1:0] ew;
      logic [ADDR_W-1:0]        er;
      logic [CH_W:0]            ed;
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (rd_pending) begin
            rd_cnt--;
            if (rd_cnt <= 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd_data;
               rd_pending = 0;
            end
         end else if (spurious) begin
            mem_rvalid = 1'($urandom_range(0, 1));
         end
         if (mem_req && prev_req && !prev_gnt) begin
            vectors++;
            if ({mem_we, mem_addr, mem_wdata} !== {prev_we, prev_addr, prev_wdata}) begin
               miscompares++;
               $display("FAIL req_stable: we/addr/wdata %b/%h/%h, required %b/%h/%h",
                        mem_we, mem_addr, mem_wdata, prev_we, prev_addr, prev_wdata);
            end
         end
         case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = 1'($urandom_range(0, 1));
            2:       mem_gnt = 1'b0;
            default: mem_gnt = !mem_we || (wr_granted < 2);
         endcase
         if (mem_req) req_cycles++;
         if (mem_req && mem_gnt) begin
            vectors++;
            if (mem_we) begin
               wr_granted++;
               wr_cyc_q.push_back(cyc);
               if (exp_wr_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL write_unexpected: addr=%h data=%h, required none", mem_addr, mem_wdata);
               end else begin
                  ew = exp_wr_q.pop_front();
                  if ({mem_addr, mem_wdata} !== ew) begin
                     miscompares++;
                     $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                              mem_addr, mem_wdata, ew[ADDR_W+DATA_W-1 -: ADDR_W], ew[DATA_W-1:0]);
                  end
               end
            end else begin
               if (exp_rd_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL read_unexpected: addr=%h, required none", mem_addr);
               end else begin
                  er = exp_rd_q.pop_front();
                  if (mem_addr !== er) begin
                     miscompares++;
                     $display("FAIL read_addr: %h, required %h", mem_addr, er);
                  end
               end
               rd_pending = 1;
               rd_cnt     = (gnt_mode == 1) ? int'($urandom_range(1, 3)) : 1;
               rd_data    = DATA_W'(mem_addr) << 1;
            end
         end
         if (done_valid) begin
            vectors++;
            done_seen++;
            done_cyc_q.push_back(cyc);
            if (exp_done_q.size() == 0) begin
               miscompares++;
               $display("FAIL done_unexpected: ch=%0d err=%b, required none", done_ch, done_err);
            end else begin
               ed = exp_done_q.pop_front();
               if ({done_ch, done_err} !== ed) begin
                  miscompares++;
                  $display("FAIL done: ch=%0d err=%b, required ch=%0d err=%b",
                           done_ch, done_err, ed[CH_W:1], ed[0]);
               end
            end
         end
         prev_req   = mem_req;
         prev_gnt   = mem_gnt;
         prev_we    = mem_we;
         prev_addr  = mem_addr;
         prev_wdata = mem_wdata;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      cmd_valid  = '0;
      rd_pending = 0;
      gnt_mode   = 0;
      spurious   = 0;
      exp_wr_q.delete();
      exp_rd_q.delete();
      exp_done_q.delete();
      wr_cyc_q.delete();
      done_cyc_q.delete();
      done_seen  = 0;
      wr_granted = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push(input int ch, input logic [1:0] op, input logic [ADDR_W-1:0] src,
                       input logic [ADDR_W-1:0] dst, input logic [LEN_W-1:0] len,
                       output int acc_cyc);
      int t = 0;
      @(negedge clk);
      cmd_op[2*ch +: 2]           = op;
      cmd_src[ch*ADDR_W +: ADDR_W] = src;
      cmd_dst[ch*ADDR_W +: ADDR_W] = dst;
      cmd_len[ch*LEN_W +: LEN_W]   = len;
      cmd_valid[ch]               = 1'b1;
      while (!cmd_ready[ch] && t < 500) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      acc_cyc       = cyc;
      cmd_valid[ch] = 1'b0;
      vectors++;
      if (t >= 500) begin
         miscompares++;
         $display("FAIL push_timeout: ch%0d waited %0d cycles, required acceptance", ch, t);
      end
   endtask

   task automatic wait_done(input int n, input string name);
      int t = 0;
      while (done_seen < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (done_seen < n) begin
         miscompares++;
         $display("FAIL %s_timeout: done count %0d, required %0d", name, done_seen, n);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({cmd_ready, mem_req, mem_we, mem_addr, mem_wdata} !== {4'hF, 1'b0, 1'b0, 16'h0, 32'h0}) begin
         miscompares++;
         $display("FAIL reset_mem: ready=%h req=%b we=%b addr=%h wdata=%h, required F/0/0/0/0",
                  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata);
      end
      vectors++;
      if ({done_valid, done_ch, done_err, busy} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_done: valid=%b ch=%0d err=%b busy=%b, required all 0",
                  done_valid, done_ch, done_err, busy);
      end
   endtask

   task automatic test_fill();
      int a;
      do_reset();
      spurious = 1;
      for (int i = 0; i < 4; i++) exp_wr_q.push_back({16'h0100 + 16'(i), 32'h0000_00AB});
      exp_done_q.push_back({2'd0, 1'b0});
      push(0, 2'b01, 16'h00AB, 16'h0100, 8'd4, a);
      wait_done(1, "fill");
      vectors++;
      if (wr_cyc_q.size() != 4) begin
         miscompares++;
         $display("FAIL fill_count: %0d writes, required 4", wr_cyc_q.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            vectors++;
            if (wr_cyc_q[i] - wr_cyc_q[i-1] != 1) begin
               miscompares++;
               $display("FAIL fill_rate: write gap %0d cycles, required 1", wr_cyc_q[i] - wr_cyc_q[i-1]);
            end
         end
      end
      spurious = 0;
   endtask

   task automatic test_copy();
      int a;
      do_reset();
      gnt_mode = 1;
      for (int i = 0; i < 3; i++) begin
         exp_rd_q.push_back(16'h0010 + 16'(i));
         exp_wr_q.push_back({16'h0020 + 16'(i), 32'h20 + 32'(2*i)});
      end
      exp_done_q.push_back({2'd2, 1'b0});
      push(2, 2'b00, 16'h0010, 16'h0020, 8'd3, a);
      wait_done(1, "copy");
      repeat (6) @(negedge clk);
      vectors++;
      if (done_seen != 1 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
         miscompares++;
         $display("FAIL copy_drain: dones=%0d wr_left=%0d rd_left=%0d, required 1/0/0",
                  done_seen, exp_wr_q.size(), exp_rd_q.size());
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 4; c++) begin
            exp_wr_q.push_back({16'h0200 + 16'(c*16 + k), 32'(c*16 + k + 1)});
            exp_done_q.push_back({2'(c), 1'b0});
         end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) begin
            cmd_op[2*c +: 2]            = 2'b01;
            cmd_src[c*ADDR_W +: ADDR_W] = 16'(c*16 + k + 1);
            cmd_dst[c*ADDR_W +: ADDR_W] = 16'h0200 + 16'(c*16 + k);
            cmd_len[c*LEN_W +: LEN_W]   = 8'd1;
         end
         cmd_valid = 4'hF;
      end
      @(negedge clk);
      cmd_valid = '0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL arb_busy: busy=%b while queued, required 1", busy);
      end
      wait_done(8, "arb");
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done_seen != 8 || exp_wr_q.size() != 0) begin
         miscompares++;
         $display("FAIL arb_end: busy=%b dones=%0d wr_left=%0d, required 0/8/0",
                  busy, done_seen, exp_wr_q.size());
      end
   endtask

   task automatic test_backpressure();
      int a;
      do_reset();
      gnt_mode = 2;
      exp_wr_q.push_back({16'h0300, 32'h55});
      exp_done_q.push_back({2'd0, 1'b0});
      for (int k = 0; k < 5; k++) begin
         exp_wr_q.push_back({16'h0310 + 16'(k), 32'h60 + 32'(k)});
         exp_done_q.push_back({2'd1, 1'b0});
      end
      push(0, 2'b01, 16'h0055, 16'h0300, 8'd1, a);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) push(1, 2'b01, 16'h0060 + 16'(k), 16'h0310 + 16'(k), 8'd1, a);
      vectors++;
      if (cmd_ready[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_full: cmd_ready[1]=%b after 4 pushes, required 0", cmd_ready[1]);
      end
      fork
         push(1, 2'b01, 16'h0064, 16'h0314, 8'd1, a);
         begin
            repeat (4) @(negedge clk);
            vectors++;
            if (cmd_ready[1] !== 1'b0 || done_seen != 0) begin
               miscompares++;
               $display("FAIL bp_hold: ready=%b dones=%0d, required 0/0", cmd_ready[1], done_seen);
            end
            gnt_mode = 0;
         end
      join
      wait_done(6, "bp");
      vectors++;
      if (exp_wr_q.size() != 0 || exp_done_q.size() != 0) begin
         miscompares++;
         $display("FAIL bp_drain: wr_left=%0d done_left=%0d, required 0/0", exp_wr_q.size(), exp_done_q.size());
      end
   endtask

   task automatic test_err_len0();
      int a3, a0, r0;
      do_reset();
      r0 = req_cycles;
      exp_done_q.push_back({2'd3, 1'b1});
      exp_done_q.push_back({2'd0, 1'b0});
      push(3, 2'b10, 16'h1111, 16'h2222, 8'd5, a3);
      push(0, 2'b00, 16'h3333, 16'h4444, 8'd0, a0);
      wait_done(2, "err");
      repeat (3) @(negedge clk);
      vectors++;
      if (req_cycles != r0) begin
         miscompares++;
         $display("FAIL err_noreq: %0d request cycles, required 0", req_cycles - r0);
      end
      vectors++;
      if (done_cyc_q.size() < 2 || done_cyc_q[0] - a3 != 2 || done_cyc_q[1] - a0 < 2) begin
         miscompares++;
         $display("FAIL err_latency: done count %0d first latency %0d, required 2 dones latency 2",
                  done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] - a3 : -1);
      end
   endtask

   task automatic test_reset_mid();
      int a, t;
      do_reset();
      gnt_mode = 3;
      exp_rd_q.push_back(16'hFFFE);
      exp_rd_q.push_back(16'hFFFF);
      exp_rd_q.push_back(16'h0000);
      exp_wr_q.push_back({16'h0400, 32'h0001_FFFC});
      exp_wr_q.push_back({16'h0401, 32'h0001_FFFE});
      push(0, 2'b00, 16'hFFFE, 16'h0400, 8'd4, a);
      t = 0;
      while (!(mem_req && mem_we && mem_addr == 16'h0402) && t < 300) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (t >= 300) begin
         miscompares++;
         $display("FAIL mid_reach: third write not seen, addr=%h, required 0402", mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_async: mem_req=%b right after reset, required 0", mem_req);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      vectors++;
      if ({cmd_ready, mem_req, busy} !== {4'hF, 1'b0, 1'b0} || done_seen != 0) begin
         miscompares++;
         $display("FAIL mid_after: ready=%h req=%b busy=%b dones=%0d, required F/0/0/0",
                  cmd_ready, mem_req, busy, done_seen);
      end
      vectors++;
      if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
         miscompares++;
         $display("FAIL mid_drain: rd_left=%0d wr_left=%0d, required 0/0", exp_rd_q.size(), exp_wr_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_copy();
      test_back_to_back();
      test_backpressure();
      test_err_len0();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule
